// File: rtl/gol_pkg.sv
// Shared types and sizing helpers for the Game of Life engine.
package gol_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CALC      = 2'd1,
    WAIT_SWAP = 2'd2
  } gol_state_e;

  localparam int GEN_CNT_W = 16;

  // Index width for a range of n values; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int cells(input int cols, input int rows);
    return cols * rows;
  endfunction

endpackage

// File: rtl/gol_rule.sv
// Conway rule for one cell: born on 3 neighbours, survives on 2 or 3.
module gol_rule (
  input  logic [7:0] i_nbr,
  input  logic       i_alive,
  output logic       o_next
);

  logic [3:0] w_n;

  always_comb begin
    w_n = 4'd0;
    for (int i = 0; i < 8; i++) w_n = w_n + {3'd0, i_nbr[i]};
  end

  assign o_next = (w_n == 4'd3) | (i_alive & (w_n == 4'd2));

endmodule

// File: rtl/gol_engine.sv
// Double-buffered Life grid: one cell per clock into the back bank,
// bank flip deferred to the next frame_tick so the display never tears.
module gol_engine
  import gol_pkg::*;
#(
  parameter int COLS       = 16,
  parameter int ROWS       = 16,
  parameter int WRAP       = 0,
  parameter int GEN_FRAMES = 60
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      frame_tick,
  input  logic                      run,
  input  logic                      step,
  input  logic                      clear,
  input  logic                      seed_we,
  input  logic [idx_w(COLS)-1:0]    seed_x,
  input  logic [idx_w(ROWS)-1:0]    seed_y,
  input  logic                      seed_val,
  input  logic [idx_w(COLS)-1:0]    rd_x,
  input  logic [idx_w(ROWS)-1:0]    rd_y,
  output logic                      rd_cell,
  output logic                      busy,
  output logic [GEN_CNT_W-1:0]      gen_count
);

  localparam int XW    = idx_w(COLS);
  localparam int YW    = idx_w(ROWS);
  localparam int CELLS = cells(COLS, ROWS);
  localparam int IW    = idx_w(CELLS);

  logic [1:0][CELLS-1:0]  r_bank;
  logic                   r_disp;
  gol_state_e             r_state;
  logic [IW-1:0]          r_idx;
  logic [XW-1:0]          r_cx;
  logic [YW-1:0]          r_cy;
  logic [7:0]             r_fcnt;
  logic [GEN_CNT_W-1:0]   r_gen;

  logic [CELLS-1:0]       w_disp;
  logic [7:0]             w_nb;
  logic                   w_next;
  logic                   w_rd_ok;
  logic                   w_seed_ok;
  logic                   w_fwrap;
  logic                   w_auto;

  function automatic logic [IW-1:0] cell_addr(input logic [XW-1:0] x, input logic [YW-1:0] y);
    return IW'(y) * IW'(COLS) + IW'(x);
  endfunction

  assign w_disp    = r_bank[r_disp];
  assign w_rd_ok   = ({1'b0, rd_x} < (XW+1)'(COLS)) && ({1'b0, rd_y} < (YW+1)'(ROWS));
  assign w_seed_ok = ({1'b0, seed_x} < (XW+1)'(COLS)) && ({1'b0, seed_y} < (YW+1)'(ROWS));
  assign rd_cell   = w_rd_ok & w_disp[cell_addr(rd_x, rd_y)];
  assign busy      = (r_state != IDLE);
  assign gen_count = r_gen;

  assign w_fwrap = (r_fcnt == 8'(GEN_FRAMES-1));
  assign w_auto  = frame_tick & run & w_fwrap;

  // Eight neighbour taps around (r_cx, r_cy); edge taps either wrap or read as dead.
  for (genvar gy = 0; gy < 3; gy++) begin : g_row
    for (genvar gx = 0; gx < 3; gx++) begin : g_col
      if (!(gy == 1 && gx == 1)) begin : g_nbr
        localparam int K = (gy*3 + gx > 4) ? gy*3 + gx - 1 : gy*3 + gx;
        logic [XW-1:0] w_nx;
        logic [YW-1:0] w_ny;
        logic          w_vx, w_vy;

        always_comb begin
          w_nx = r_cx;
          w_vx = 1'b1;
          if (gx == 0) begin
            if (r_cx == '0) begin
              w_nx = XW'(COLS-1);
              w_vx = (WRAP != 0);
            end else w_nx = r_cx - 1'b1;
          end else if (gx == 2) begin
            if (r_cx == XW'(COLS-1)) begin
              w_nx = '0;
              w_vx = (WRAP != 0);
            end else w_nx = r_cx + 1'b1;
          end
          w_ny = r_cy;
          w_vy = 1'b1;
          if (gy == 0) begin
            if (r_cy == '0) begin
              w_ny = YW'(ROWS-1);
              w_vy = (WRAP != 0);
            end else w_ny = r_cy - 1'b1;
          end else if (gy == 2) begin
            if (r_cy == YW'(ROWS-1)) begin
              w_ny = '0;
              w_vy = (WRAP != 0);
            end else w_ny = r_cy + 1'b1;
          end
        end

        assign w_nb[K] = w_vx & w_vy & w_disp[cell_addr(w_nx, w_ny)];
      end
    end
  end

  gol_rule u_rule (
    .i_nbr   (w_nb),
    .i_alive (w_disp[r_idx]),
    .o_next  (w_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bank  <= '0;
      r_disp  <= 1'b0;
      r_state <= IDLE;
      r_idx   <= '0;
      r_cx    <= '0;
      r_cy    <= '0;
      r_fcnt  <= '0;
      r_gen   <= '0;
    end else begin
      if (frame_tick) r_fcnt <= w_fwrap ? 8'd0 : r_fcnt + 8'd1;

      case (r_state)
        IDLE: begin
          if (clear) begin
            r_bank <= '0;
            r_gen  <= '0;
          end else if (seed_we) begin
            if (w_seed_ok) r_bank[r_disp][cell_addr(seed_x, seed_y)] <= seed_val;
          end else if (step || w_auto) begin
            r_state <= CALC;
            r_idx   <= '0;
            r_cx    <= '0;
            r_cy    <= '0;
          end
        end
        CALC: begin
          r_bank[~r_disp][r_idx] <= w_next;
          if (r_idx == IW'(CELLS-1)) begin
            r_state <= WAIT_SWAP;
          end else begin
            r_idx <= r_idx + 1'b1;
            if (r_cx == XW'(COLS-1)) begin
              r_cx <= '0;
              r_cy <= r_cy + 1'b1;
            end else r_cx <= r_cx + 1'b1;
          end
        end
        WAIT_SWAP: begin
          if (frame_tick) begin
            r_disp  <= ~r_disp;
            r_gen   <= r_gen + 1'b1;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gol_engine.sv
// Directed bench: two 16x16 engines (no wrap / wrap) share stimulus, an 8x6 wrap engine runs the glider.
module tb_gol_engine;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       frame_tick = 0, run = 0, step = 0, clear = 0, seed_we = 0, seed_val = 0;
  logic [3:0] seed_x = 0, seed_y = 0, rd_x = 0, rd_y = 0;
  logic       rd_a, rd_b, busy_a, busy_b;
  logic [15:0] gen_a, gen_b;

  logic       c_step = 0, c_seed_we = 0, c_seed_val = 0;
  logic [2:0] c_sx = 0, c_sy = 0, c_rx = 0, c_ry = 0;
  logic       c_rd, c_busy;
  logic [15:0] c_gen;

  int checks = 0;
  int failures = 0;

  bit mg [64][64];
  bit mt [64][64];

  gol_engine #(.COLS(16), .ROWS(16), .WRAP(0), .GEN_FRAMES(2)) u_a (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .run(run), .step(step), .clear(clear),
    .seed_we(seed_we), .seed_x(seed_x), .seed_y(seed_y), .seed_val(seed_val),
    .rd_x(rd_x), .rd_y(rd_y), .rd_cell(rd_a), .busy(busy_a), .gen_count(gen_a));

  gol_engine #(.COLS(16), .ROWS(16), .WRAP(1), .GEN_FRAMES(2)) u_b (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .run(run), .step(step), .clear(clear),
    .seed_we(seed_we), .seed_x(seed_x), .seed_y(seed_y), .seed_val(seed_val),
    .rd_x(rd_x), .rd_y(rd_y), .rd_cell(rd_b), .busy(busy_b), .gen_count(gen_b));

  gol_engine #(.COLS(8), .ROWS(6), .WRAP(1), .GEN_FRAMES(60)) u_c (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .run(1'b0), .step(c_step), .clear(1'b0),
    .seed_we(c_seed_we), .seed_x(c_sx), .seed_y(c_sy), .seed_val(c_seed_val),
    .rd_x(c_rx), .rd_y(c_ry), .rd_cell(c_rd), .busy(c_busy), .gen_count(c_gen));

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_rst;
    rst_n = 0; cyc(2); rst_n = 1; cyc(1);
  endtask

  task automatic pulse_step;
    step = 1; cyc(1); step = 0;
  endtask

  task automatic pulse_tick;
    frame_tick = 1; cyc(1); frame_tick = 0;
  endtask

  task automatic pulse_clear;
    clear = 1; cyc(1); clear = 0;
  endtask

  task automatic seed_ab(input int x, input int y, input bit v);
    seed_x = 4'(x); seed_y = 4'(y); seed_val = v; seed_we = 1; cyc(1); seed_we = 0;
  endtask

  task automatic seed_c(input int x, input int y, input bit v);
    c_sx = 3'(x); c_sy = 3'(y); c_seed_val = v; c_seed_we = 1; cyc(1); c_seed_we = 0;
  endtask

  task automatic rd_ab(input int x, input int y, output bit a, output bit b);
    rd_x = 4'(x); rd_y = 4'(y); @(negedge clk); a = rd_a; b = rd_b;
  endtask

  task automatic rd_c(input int x, input int y, output bit v);
    c_rx = 3'(x); c_ry = 3'(y); @(negedge clk); v = c_rd;
  endtask

  task automatic model_clear;
    for (int y = 0; y < 64; y++) for (int x = 0; x < 64; x++) mg[y][x] = 0;
  endtask

  task automatic model_step(input int cols, input int rows, input bit wrap);
    for (int y = 0; y < rows; y++) begin
      for (int x = 0; x < cols; x++) begin
        int n;
        n = 0;
        for (int dy = -1; dy <= 1; dy++) begin
          for (int dx = -1; dx <= 1; dx++) begin
            int nx, ny;
            if (dx == 0 && dy == 0) continue;
            nx = x + dx; ny = y + dy;
            if (wrap) n += int'(mg[(ny + rows) % rows][(nx + cols) % cols]);
            else if (nx >= 0 && nx < cols && ny >= 0 && ny < rows) n += int'(mg[ny][nx]);
          end
        end
        mt[y][x] = (n == 3) || (mg[y][x] && n == 2);
      end
    end
    for (int y = 0; y < rows; y++) for (int x = 0; x < cols; x++) mg[y][x] = mt[y][x];
  endtask

  // Counts cells where the selected 16x16 engine disagrees with the model.
  task automatic scan_ab(input bit sel_b, output int mism);
    bit a, b;
    mism = 0;
    for (int y = 0; y < 16; y++) for (int x = 0; x < 16; x++) begin
      rd_ab(x, y, a, b);
      if ((sel_b ? b : a) != mg[y][x]) mism++;
    end
  endtask

  task automatic scan_c(output int mism);
    bit v;
    mism = 0;
    for (int y = 0; y < 6; y++) for (int x = 0; x < 8; x++) begin
      rd_c(x, y, v);
      if (v != mg[y][x]) mism++;
    end
  endtask

  task automatic test_reset;
    int m;
    do_rst();
    checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy_a); end
    checks++; if (gen_a !== 16'd0) begin failures++; $display("FAIL reset_gen got=%0d exp=0", gen_a); end
    checks++; if (c_busy !== 1'b0 || c_gen !== 16'd0) begin failures++; $display("FAIL reset_c busy=%0b gen=%0d exp=0/0", c_busy, c_gen); end
    model_clear();
    scan_ab(0, m);
    checks++; if (m != 0) begin failures++; $display("FAIL reset_grid mismatches=%0d exp=0", m); end
  endtask

  task automatic test_blinker;
    bit a, b;
    int m, cnt;
    model_clear();
    seed_ab(7, 6, 1); seed_ab(7, 7, 1); seed_ab(7, 8, 1);
    mg[6][7] = 1; mg[7][7] = 1; mg[8][7] = 1;
    rd_ab(7, 8, a, b);
    checks++; if (a !== 1'b1) begin failures++; $display("FAIL blinker_seed_visible got=%0b exp=1", a); end
    pulse_step();
    checks++; if (busy_a !== 1'b1) begin failures++; $display("FAIL blinker_busy_start got=%0b exp=1", busy_a); end
    cyc(300);
    checks++; if (busy_a !== 1'b1) begin failures++; $display("FAIL blinker_wait_swap got=%0b exp=1", busy_a); end
    rd_ab(7, 6, a, b);
    checks++; if (a !== 1'b1) begin failures++; $display("FAIL blinker_no_tear got=%0b exp=1", a); end
    pulse_tick();
    checks++; if (busy_a !== 1'b0 || gen_a !== 16'd1) begin failures++; $display("FAIL blinker_gen1 busy=%0b gen=%0d exp=0/1", busy_a, gen_a); end
    begin
      bit c0, c1, c2, c3, c4;
      rd_ab(6, 7, c0, b); rd_ab(7, 7, c1, b); rd_ab(8, 7, c2, b); rd_ab(7, 6, c3, b); rd_ab(7, 8, c4, b);
      checks++;
      if ({c0, c1, c2, c3, c4} !== 5'b11100) begin
        failures++; $display("FAIL blinker_horizontal got=%b exp=11100", {c0, c1, c2, c3, c4});
      end
    end
    model_step(16, 16, 0);
    scan_ab(0, m);
    checks++; if (m != 0) begin failures++; $display("FAIL blinker_grid1 mismatches=%0d exp=0", m); end
    // Second generation with frame_tick held high: busy spans CALC plus one swap cycle.
    pulse_step();
    frame_tick = 1;
    cnt = 0;
    while (busy_a && cnt < 400) begin cyc(1); cnt++; end
    frame_tick = 0;
    checks++; if (cnt != 257) begin failures++; $display("FAIL blinker_latency busy_cycles=%0d exp=257", cnt); end
    model_step(16, 16, 0);
    scan_ab(0, m);
    checks++; if (m != 0 || gen_a !== 16'd2) begin failures++; $display("FAIL blinker_vertical mismatches=%0d gen=%0d exp=0/2", m, gen_a); end
  endtask

  task automatic test_block_run;
    int m;
    do_rst();
    model_clear();
    seed_ab(0, 0, 1); seed_ab(1, 0, 1); seed_ab(0, 1, 1); seed_ab(1, 1, 1);
    mg[0][0] = 1; mg[0][1] = 1; mg[1][0] = 1; mg[1][1] = 1;
    pulse_tick();  // frame counter 0 -> 1 with run low
    cyc(2);
    run = 1;
    repeat (6) begin pulse_tick(); cyc(300); end
    run = 0;
    checks++; if (gen_a !== 16'd3 || busy_a !== 1'b0) begin failures++; $display("FAIL block_gen gen=%0d busy=%0b exp=3/0", gen_a, busy_a); end
    scan_ab(0, m);
    checks++; if (m != 0) begin failures++; $display("FAIL block_still mismatches=%0d exp=0", m); end
  endtask

  task automatic test_edge_wrap;
    int m;
    bit a, b;
    pulse_clear();
    seed_ab(15, 5, 1); seed_ab(0, 5, 1); seed_ab(1, 5, 1);
    pulse_step(); cyc(260); pulse_tick();
    begin
      bit w0, w1, w2, w3, w4;
      rd_ab(0, 4, a, w0); rd_ab(0, 5, a, w1); rd_ab(0, 6, a, w2); rd_ab(15, 5, a, w3); rd_ab(1, 5, a, w4);
      checks++;
      if ({w0, w1, w2, w3, w4} !== 5'b11100) begin
        failures++; $display("FAIL wrap_vertical got=%b exp=11100", {w0, w1, w2, w3, w4});
      end
    end
    model_clear();
    mg[5][15] = 1; mg[5][0] = 1; mg[5][1] = 1;
    model_step(16, 16, 1);
    scan_ab(1, m);
    checks++; if (m != 0) begin failures++; $display("FAIL wrap_grid mismatches=%0d exp=0", m); end
    model_clear();
    mg[5][15] = 1; mg[5][0] = 1; mg[5][1] = 1;
    model_step(16, 16, 0);
    scan_ab(0, m);
    checks++; if (m != 0) begin failures++; $display("FAIL nowrap_grid mismatches=%0d exp=0", m); end
  endtask

  task automatic test_contention;
    int m;
    bit a, b;
    seed_ab(3, 3, 1);
    clear = 1; seed_we = 1; seed_x = 4; seed_y = 4; seed_val = 1; step = 1;
    cyc(1);
    clear = 0; seed_we = 0; step = 0;
    checks++; if (busy_a !== 1'b0 || gen_a !== 16'd0) begin failures++; $display("FAIL contend_idle busy=%0b gen=%0d exp=0/0", busy_a, gen_a); end
    model_clear();
    scan_ab(0, m);
    checks++; if (m != 0) begin failures++; $display("FAIL contend_zero mismatches=%0d exp=0", m); end
    checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL contend_stays_idle got=%0b exp=0", busy_a); end
    pulse_step(); cyc(50);
    pulse_step();
    seed_ab(10, 10, 1);
    cyc(250);
    rd_ab(10, 10, a, b);
    checks++; if (a !== 1'b0) begin failures++; $display("FAIL busy_seed_ignored got=%0b exp=0", a); end
    pulse_tick();
    cyc(5);
    checks++; if (gen_a !== 16'd1 || busy_a !== 1'b0) begin failures++; $display("FAIL busy_step_ignored gen=%0d busy=%0b exp=1/0", gen_a, busy_a); end
  endtask

  task automatic test_reset_mid_calc;
    int m;
    pulse_clear();
    seed_ab(7, 6, 1); seed_ab(7, 7, 1); seed_ab(7, 8, 1);
    pulse_step();
    cyc(100);
    rst_n = 0;
    #1;
    checks++; if (busy_a !== 1'b0 || gen_a !== 16'd0) begin failures++; $display("FAIL midcalc_rst busy=%0b gen=%0d exp=0/0", busy_a, gen_a); end
    cyc(2); rst_n = 1; cyc(1);
    model_clear();
    scan_ab(0, m);
    checks++; if (m != 0) begin failures++; $display("FAIL midcalc_grid mismatches=%0d exp=0", m); end
    pulse_step(); cyc(260); pulse_tick();
    scan_ab(0, m);
    checks++; if (m != 0 || gen_a !== 16'd1) begin failures++; $display("FAIL midcalc_empty_gen mismatches=%0d gen=%0d exp=0/1", m, gen_a); end
  endtask

  task automatic test_glider;
    int m, bad_gens;
    bit v;
    model_clear();
    seed_c(1, 0, 1); seed_c(2, 1, 1); seed_c(0, 2, 1); seed_c(1, 2, 1); seed_c(2, 2, 1);
    seed_c(2, 7, 1);  // row out of range, must be dropped
    mg[0][1] = 1; mg[1][2] = 1; mg[2][0] = 1; mg[2][1] = 1; mg[2][2] = 1;
    scan_c(m);
    checks++; if (m != 0) begin failures++; $display("FAIL glider_seed mismatches=%0d exp=0", m); end
    bad_gens = 0;
    for (int g = 1; g <= 32; g++) begin
      c_step = 1; cyc(1); c_step = 0;
      cyc(52); pulse_tick();
      model_step(8, 6, 1);
      scan_c(m);
      if (m != 0) bad_gens++;
      if (g == 4) begin
        bit c0, c1, c2, c3, c4, c5;
        rd_c(2, 1, c0); rd_c(3, 2, c1); rd_c(1, 3, c2); rd_c(2, 3, c3); rd_c(3, 3, c4); rd_c(1, 0, c5);
        checks++;
        if ({c0, c1, c2, c3, c4, c5} !== 6'b111110) begin
          failures++; $display("FAIL glider_gen4_shift got=%b exp=111110", {c0, c1, c2, c3, c4, c5});
        end
      end
    end
    checks++; if (bad_gens != 0) begin failures++; $display("FAIL glider_model bad_generations=%0d exp=0", bad_gens); end
    checks++; if (c_gen !== 16'd32) begin failures++; $display("FAIL glider_gen got=%0d exp=32", c_gen); end
    rd_c(1, 6, v);
    checks++; if (v !== 1'b0) begin failures++; $display("FAIL glider_rd_oob got=%0b exp=0", v); end
  endtask

  initial begin
    test_reset();
    test_blinker();
    test_block_run();
    test_edge_wrap();
    test_contention();
    test_reset_mid_calc();
    test_glider();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
